uart_tx_frame_engine: RTL and testbench
=======================================

// Module: uart_tx_frame_engine
// PURPOSE
// UART transmitter, the counterpart to the oversampled UART receiver. Takes a
// parallel byte via a valid/busy handshake and serialises it as start bit,
// DATA_WIDTH data bits (LSB first), optional parity bit and one stop bit.
// Each bit is held for `prescale` CLK cycles, so TX and RX share one clock and
// one prescale configuration.
// PARAMETERS
// DATA_WIDTH   8   payload bits per frame
// PRESCALE_W   6   width of prescale input and internal edge counter
// PORTS
// CLK         in   1            system clock, all logic on rising edge
// RST         in   1            asynchronous, active-high reset
// P_DATA      in   DATA_WIDTH   byte to send, sampled on accept
// DATA_VALID  in   1            request to send P_DATA
// PAR_EN      in   1            1 = insert parity bit
// PAR_TYP     in   1            0 = even parity, 1 = odd parity
// prescale    in   PRESCALE_W   CLK cycles per bit
// TX_OUT      out  1            serial line, idles high, registered
// busy        out  1            high while a frame is in progress
// done        out  1            one-cycle pulse when a frame completes
// BEHAVIOUR
// - Reset (async, any time incl. mid-frame): state=IDLE, TX_OUT=1, busy=0,
//   done=0, edge_cnt=0, bit_cnt=0, shift register=0. Partial frame abandoned.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
// - Accept: in IDLE, DATA_VALID=1 at a rising edge -> same edge latches
//   P_DATA, PAR_EN, PAR_TYP, prescale; state<=START, TX_OUT<=0, busy<=1.
//   Inputs changing after accept have no effect on the current frame.
// - DATA_VALID outside IDLE is ignored (not queued). Producer must hold
//   DATA_VALID until it sees busy=1 or simply pulse it while busy=0.
// - Bit timing: edge_cnt counts 0..P-1 per bit, P = latched prescale;
//   P=0 treated as P=1. On edge_cnt==P-1: edge_cnt<=0, advance to next bit.
// - START: TX_OUT=0 for P cycles -> DATA.
// - DATA: TX_OUT=data[bit_cnt], bit_cnt 0..DATA_WIDTH-1, P cycles each;
//   after last bit -> PARITY if PAR_EN latched =1, else STOP.
// - PARITY: TX_OUT = ^data (even) or ~^data (odd), computed from latched
//   data, P cycles -> STOP.
// - STOP: TX_OUT=1 for P cycles. On last stop cycle edge: state<=IDLE,
//   busy<=0, done<=1 for exactly one cycle; TX_OUT stays 1.
// - Frame length: (DATA_WIDTH+2+PAR_EN)*P cycles from accept edge to done.
// - Minimum one IDLE cycle between frames (new accept earliest on the edge
//   where done=1 is visible, i.e. one cycle after busy falls... busy=0 and
//   state=IDLE at that edge allow accept).
// - All outputs registered; no combinational path input->output.
// - bit_cnt width = clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.
// TESTING
// 1. P=8, PAR_EN=0, P_DATA=0xA5 -> TX_OUT: 0 then 1,0,1,0,0,1,0,1 then 1, each
//    8 cycles; busy high 80 cycles; done pulse on cycle 80.
// 2. P=4, PAR_EN=1, PAR_TYP=0, 0xA5 -> parity bit 0; PAR_TYP=1 -> parity 1;
//    frame 44 cycles.
// 3. P=1 and P=0, 0xFF, PAR_EN=1 even -> 11-cycle frame, each bit 1 cycle,
//    parity 0.
// 4. DATA_VALID pulsed with 0x3C mid-frame of 0x81 -> ignored; only 0x81 sent,
//    then 0x3C sent only when re-requested in IDLE.
// 5. Change prescale/PAR_EN/P_DATA mid-frame -> current frame unchanged.
// 6. Assert RST during DATA bit 3 -> TX_OUT=1, busy=0, done=0 immediately;
//    after release, new request sends a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_frame_engine_if.sv
// Handshake and serial-line bundle between a byte producer and the UART frame transmitter.
// The producer drives the request side; the transmitter drives the line and status flags.
interface uart_tx_frame_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] prescale;
    logic                  TX_OUT;
    logic                  busy;
    logic                  done;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, busy, done
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, busy, done
    );
endinterface

// File: rtl/uart_tx_frame_engine.sv
// UART transmitter: start bit, LSB-first payload, optional parity, one stop bit.
// Each bit lasts a prescale number of clocks; the frame settings are frozen at accept.
module uart_tx_frame_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_frame_engine_if.slave bus
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q,    state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic [PRESCALE_W-1:0] presc_q,    presc_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_typ_q,  par_typ_d;
    logic                  tx_q,       tx_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic [PRESCALE_W-1:0] p_last_s;
    logic [PRESCALE_W-1:0] edge_cnt_inc_s;
    logic [BIT_W-1:0]      bit_cnt_inc_s;
    logic                  bit_end_s;
    logic                  parity_s;

    // Even parity is the XOR of the payload; odd parity inverts it.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Bit-period bookkeeping; a latched prescale of zero behaves as one clock per bit.
    always_comb begin
        p_last_s       = (presc_q == {PRESCALE_W{1'b0}}) ? {PRESCALE_W{1'b0}}
                                                         : presc_q - PRESCALE_W'(1);
        bit_end_s      = (edge_cnt_q == p_last_s);
        edge_cnt_inc_s = bit_end_s ? {PRESCALE_W{1'b0}} : edge_cnt_q + PRESCALE_W'(1);
        bit_cnt_inc_s  = bit_cnt_q + BIT_W'(1);
        parity_s       = calc_parity(data_q, par_typ_q);
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    state_d    = START;
                    data_d     = bus.P_DATA;
                    par_en_d   = bus.PAR_EN;
                    par_typ_d  = bus.PAR_TYP;
                    presc_d    = bus.prescale;
                    edge_cnt_d = {PRESCALE_W{1'b0}};
                    bit_cnt_d  = {BIT_W{1'b0}};
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                edge_cnt_d = edge_cnt_inc_s;
                if (bit_end_s) begin
                    state_d   = DATA;
                    bit_cnt_d = {BIT_W{1'b0}};
                    tx_d      = data_q[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            DATA: begin
                edge_cnt_d = edge_cnt_inc_s;
                if (bit_end_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = parity_s;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_inc_s;
                        tx_d      = data_q[bit_cnt_inc_s];
                    end
                end else begin
                    tx_d = data_q[bit_cnt_q];
                end
            end
            PARITY: begin
                edge_cnt_d = edge_cnt_inc_s;
                if (bit_end_s) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    tx_d = parity_s;
                end
            end
            STOP: begin
                edge_cnt_d = edge_cnt_inc_s;
                tx_d       = 1'b1;
                if (bit_end_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = {PRESCALE_W{1'b0}};
                bit_cnt_d  = {BIT_W{1'b0}};
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= {PRESCALE_W{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
            data_q     <= {DATA_WIDTH{1'b0}};
            presc_q    <= {PRESCALE_W{1'b0}};
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Scoreboard bench: each request pushes its expected line waveform; a monitor captures
// the line while busy and compares when done pulses.
module tb_uart_tx_frame_engine;

    logic CLK;
    logic RST;

    uart_tx_frame_engine_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_tx_frame_engine #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] wave;
        int           len;
        logic [7:0]   data;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [127:0] act_wave = '0;
    int           act_len  = 0;
    logic         done_prev = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // bits: hand-computed frame, bit 0 = start bit (sent first), bit nbits-1 = stop bit
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] p, input logic [10:0] bits, input int nbits,
                        input logic push);
        exp_t e;
        int   n;
        int   idx;
        int   peff;
        n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (bus.busy) begin
            failures++;
            checks++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", bus.busy, n);
        end
        peff = (p == 6'd0) ? 1 : int'(p);
        e.wave = '0;
        e.data = d;
        idx = 0;
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < peff; k++) begin
                if (idx < 128) e.wave[idx] = bits[i];
                idx++;
            end
        end
        e.len = idx;
        if (push) sb.push_back(e);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.prescale   = p;
        bus.DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.DATA_VALID = 1'b0;
    endtask

    // Monitor: capture the line while busy, compare against the scoreboard on done.
    always @(negedge CLK) begin
        if (RST) begin
            act_len   = 0;
            act_wave  = '0;
            done_prev = 1'b0;
        end else begin
            if (bus.busy) begin
                if (act_len < 128) act_wave[act_len] = bus.TX_OUT;
                act_len++;
            end else begin
                checks++;
                if (bus.TX_OUT !== 1'b1) begin
                    failures++;
                    $display("FAIL idle_line: TX_OUT=%b expected 1", bus.TX_OUT);
                end
            end
            if (bus.done) begin
                checks++;
                if (done_prev) begin
                    failures++;
                    $display("FAIL done_width: done high for 2+ cycles, expected 1-cycle pulse");
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: frame of %0d cycles with empty scoreboard", act_len);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if (act_len != e.len) begin
                        failures++;
                        $display("FAIL frame_len_%h: got %0d cycles expected %0d", e.data, act_len, e.len);
                    end
                    checks++;
                    if (act_wave !== e.wave) begin
                        failures++;
                        $display("FAIL frame_wave_%h: got %h expected %h", e.data, act_wave, e.wave);
                    end
                end
                act_len  = 0;
                act_wave = '0;
            end
            done_prev = bus.done;
        end
    end

    initial begin
        int n;
        RST            = 1'b1;
        bus.P_DATA     = 8'h00;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.prescale   = 6'd0;
        repeat (3) @(negedge CLK);
        chk("reset_tx",   {127'd0, bus.TX_OUT}, 128'd1);
        chk("reset_busy", {127'd0, bus.busy},   128'd0);
        chk("reset_done", {127'd0, bus.done},   128'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: P=8, no parity, 0xA5 -> 80-cycle frame
        send(8'hA5, 1'b0, 1'b0, 6'd8, {1'b0, 10'b1_1010_0101_0}, 10, 1'b1);
        // 2: P=4, parity even (0) and odd (1), 44-cycle frames
        send(8'hA5, 1'b1, 1'b0, 6'd4, 11'b1_0_1010_0101_0, 11, 1'b1);
        send(8'hA5, 1'b1, 1'b1, 6'd4, 11'b1_1_1010_0101_0, 11, 1'b1);
        // 3: P=1 and P=0, 0xFF even parity -> 11-cycle frames, parity 0
        send(8'hFF, 1'b1, 1'b0, 6'd1, 11'b1_0_1111_1111_0, 11, 1'b1);
        send(8'hFF, 1'b1, 1'b0, 6'd0, 11'b1_0_1111_1111_0, 11, 1'b1);

        // 4: request for 0x3C while 0x81 is in flight must be dropped
        send(8'h81, 1'b0, 1'b0, 6'd4, {1'b0, 10'b1_1000_0001_0}, 10, 1'b1);
        repeat (10) @(negedge CLK);
        bus.P_DATA     = 8'h3C;
        bus.DATA_VALID = 1'b1;
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        send(8'h3C, 1'b0, 1'b0, 6'd4, {1'b0, 10'b1_0011_1100_0}, 10, 1'b1);

        // 5: inputs change after accept; frame keeps 0xC3, P=3, odd parity (1)
        send(8'hC3, 1'b1, 1'b1, 6'd3, 11'b1_1_1100_0011_0, 11, 1'b1);
        bus.P_DATA   = 8'h00;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.prescale = 6'd7;

        // 6: reset during data bit 3 of 0x96 (bit 3 = 0), then a clean frame
        send(8'h96, 1'b0, 1'b0, 6'd4, {1'b0, 10'b1_1001_0110_0}, 10, 1'b0);
        repeat (17) @(posedge CLK);
        #2;
        chk("pre_rst_tx",   {127'd0, bus.TX_OUT}, 128'd0);
        chk("pre_rst_busy", {127'd0, bus.busy},   128'd1);
        RST = 1'b1;
        #1;
        chk("rst_mid_tx",   {127'd0, bus.TX_OUT}, 128'd1);
        chk("rst_mid_busy", {127'd0, bus.busy},   128'd0);
        chk("rst_mid_done", {127'd0, bus.done},   128'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        send(8'h5A, 1'b1, 1'b0, 6'd2, 11'b1_0_0101_1010_0, 11, 1'b1);

        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d frames outstanding, expected 0", sb.size());
        end
        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
